// File: rtl/audioport_pkg.sv
// Shared types and default sizing for the audio frame FIFO slice.
package audioport_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } fifo_state_t;

    localparam int FIFO_DEPTH   = 8;
    localparam int FIFO_PREFILL = 4;

endpackage

// File: rtl/audio_frame_fifo_if.sv
// Frame write / request-read handshake between the sample source, the output path and the FIFO.
interface audio_frame_fifo_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 24
);
    localparam int FRAME_W = CHANNELS * SAMPLE_W;

    logic               tick_in;
    logic [FRAME_W-1:0] audio_in;
    logic               req_in;
    logic [FRAME_W-1:0] audio_out;
    logic               tick_out;

    modport master (
        output tick_in, audio_in, req_in,
        input  audio_out, tick_out
    );

    modport slave (
        input  tick_in, audio_in, req_in,
        output audio_out, tick_out
    );

endinterface

// File: rtl/audio_fifo_mem.sv
// Frame storage: synchronous write port, combinational read port, no reset on data.
module audio_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 48
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/audio_frame_fifo.sv
// Multi-channel audio frame buffer with prefill threshold, sticky underrun/overflow
// flags, registered fill level and a play-gated flush.
module audio_frame_fifo
    import audioport_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 24,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int PREFILL  = FIFO_PREFILL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     play_in,
    input  logic                     clr_in,
    audio_frame_fifo_if.slave        bus,
    output logic [$clog2(DEPTH):0]   level_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic                     underrun_out,
    output logic                     overflow_out,
    output logic [1:0]               state_out
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int FRAME_W = CHANNELS * SAMPLE_W;

    fifo_state_t        r_state;
    fifo_state_t        w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_nxt;
    logic               r_full;
    logic               r_empty;
    logic               r_underrun;
    logic               r_overflow;
    logic [FRAME_W-1:0] r_audio;
    logic               r_tick;
    logic [FRAME_W-1:0] w_rd_data;
    logic               w_active;
    logic               w_push;
    logic               w_pop;
    logic               w_under;
    logic               w_over;

    audio_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.audio_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // A pop frees the slot in the same edge, so a write while full is accepted when paired with one.
    always_comb begin
        w_active    = play_in && (r_state == FILL || r_state == RUN);
        w_pop       = play_in && (r_state == RUN) && bus.req_in && (r_level != '0);
        w_push      = w_active && bus.tick_in && ((r_level != LVL_W'(DEPTH)) || w_pop);
        w_over      = w_active && bus.tick_in && (r_level == LVL_W'(DEPTH)) && !w_pop;
        w_under     = play_in && (r_state == RUN) && bus.req_in && (r_level == '0);
        w_level_nxt = r_level;
        if (!w_active) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (play_in) w_state_nxt = FILL;
            FILL:    if (w_level_nxt >= LVL_W'(PREFILL)) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
        if (!play_in) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
            r_audio    <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= bus.req_in;
            if (!w_active) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
            r_empty <= (w_level_nxt == '0);
            if (!play_in) begin
                r_audio <= '0;
            end else if (bus.req_in) begin
                r_audio <= w_pop ? w_rd_data : '0;
            end
            // Set events override a same-cycle clear.
            r_underrun <= w_under | (r_underrun & ~clr_in);
            r_overflow <= w_over  | (r_overflow & ~clr_in);
        end
    end

    assign bus.audio_out = r_audio;
    assign bus.tick_out  = r_tick;
    assign level_out     = r_level;
    assign full_out      = r_full;
    assign empty_out     = r_empty;
    assign underrun_out  = r_underrun;
    assign overflow_out  = r_overflow;
    assign state_out     = r_state;

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Drives two FIFO configurations with identical control traffic and scores them against a queue model.
module tb_audio_frame_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play = 1'b0;
    logic        clr = 1'b0;
    logic        tick = 1'b0;
    logic        req = 1'b0;
    logic [63:0] din = '0;

    always #5 clk = ~clk;

    audio_frame_fifo_if #(.CHANNELS(2), .SAMPLE_W(24)) bus_a ();
    audio_frame_fifo_if #(.CHANNELS(4), .SAMPLE_W(16)) bus_b ();

    assign bus_a.tick_in  = tick;
    assign bus_a.req_in   = req;
    assign bus_a.audio_in = din[47:0];
    assign bus_b.tick_in  = tick;
    assign bus_b.req_in   = req;
    assign bus_b.audio_in = din;

    logic [3:0] lvl_a;
    logic [4:0] lvl_b;
    logic       full_a, empty_a, und_a, ovf_a;
    logic       full_b, empty_b, und_b, ovf_b;
    logic [1:0] st_a, st_b;

    audio_frame_fifo #(.CHANNELS(2), .SAMPLE_W(24), .DEPTH(8), .PREFILL(4)) dut_a (
        .clk(clk), .rst(rst), .play_in(play), .clr_in(clr), .bus(bus_a),
        .level_out(lvl_a), .full_out(full_a), .empty_out(empty_a),
        .underrun_out(und_a), .overflow_out(ovf_a), .state_out(st_a)
    );

    audio_frame_fifo #(.CHANNELS(4), .SAMPLE_W(16), .DEPTH(16), .PREFILL(1)) dut_b (
        .clk(clk), .rst(rst), .play_in(play), .clr_in(clr), .bus(bus_b),
        .level_out(lvl_b), .full_out(full_b), .empty_out(empty_b),
        .underrun_out(und_b), .overflow_out(ovf_b), .state_out(st_b)
    );

    // Reference model: a frame queue per configuration plus state/flag bookkeeping.
    int          m_depth [2] = '{8, 16};
    int          m_pre   [2] = '{4, 1};
    bit [63:0]   m_mask  [2] = '{64'h0000_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    bit [63:0]   mq      [2][$];
    bit [63:0]   sb      [2][$];
    int          m_state [2];
    bit          m_und   [2];
    bit          m_ovf   [2];
    bit          m_tick  [2];
    bit [63:0]   m_out   [2];
    bit          mon_en = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic model(input int d);
        bit        pop;
        int        size0;
        bit [63:0] f;
        if (rst) begin
            mq[d].delete();
            m_state[d] = 0; m_und[d] = 0; m_ovf[d] = 0; m_tick[d] = 0; m_out[d] = '0;
            return;
        end
        m_tick[d] = req;
        if (clr) begin
            m_und[d] = 0; m_ovf[d] = 0;
        end
        if (!play) begin
            mq[d].delete();
            m_state[d] = 0;
            m_out[d]   = '0;
            if (req) sb[d].push_back('0);
            return;
        end
        size0 = mq[d].size();
        pop   = req && m_state[d] == 2 && size0 > 0;
        if (req) begin
            f = pop ? mq[d].pop_front() : 64'd0;
            m_out[d] = f;
            sb[d].push_back(f);
            if (m_state[d] == 2 && !pop) m_und[d] = 1;
        end
        if (tick && m_state[d] != 0) begin
            if (size0 < m_depth[d] || pop) mq[d].push_back(din & m_mask[d]);
            else m_ovf[d] = 1;
        end
        if (m_state[d] == 0) m_state[d] = 1;
        else if (m_state[d] == 1 && mq[d].size() >= m_pre[d]) m_state[d] = 2;
    endtask

    task automatic step(input bit p, input bit t, input bit r, input bit c,
                        input bit rs, input logic [63:0] data);
        @(negedge clk);
        #1;
        rst = rs; play = p; tick = t; req = r; clr = c; din = data;
        model(0);
        model(1);
        mon_en = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int d, input logic [63:0] lvl, input logic full, input logic empty,
                       input logic und, input logic ovf, input logic [1:0] st,
                       input logic tk, input logic [63:0] aout);
        string p;
        p = (d == 0) ? "a" : "b";
        chk({p, ".level"}, lvl, 64'(mq[d].size()));
        chk({p, ".full"}, 64'(full), 64'(mq[d].size() == m_depth[d]));
        chk({p, ".empty"}, 64'(empty), 64'(mq[d].size() == 0));
        chk({p, ".underrun"}, 64'(und), 64'(m_und[d]));
        chk({p, ".overflow"}, 64'(ovf), 64'(m_ovf[d]));
        chk({p, ".state"}, 64'(st), 64'(m_state[d]));
        chk({p, ".tick_out"}, 64'(tk), 64'(m_tick[d]));
        chk({p, ".audio_hold"}, aout, m_out[d]);
        if (tk === 1'b1) begin
            if (sb[d].size() == 0) chk({p, ".unexpected_tick"}, 64'd1, 64'd0);
            else chk({p, ".frame"}, aout, sb[d].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, 64'(lvl_a), full_a, empty_a, und_a, ovf_a, st_a, bus_a.tick_out, 64'(bus_a.audio_out));
            mon(1, 64'(lvl_b), full_b, empty_b, und_b, ovf_b, st_b, bus_b.tick_out, 64'(bus_b.audio_out));
        end
    end

    initial begin
        step(0, 0, 0, 0, 1, '0);
        step(0, 1, 1, 0, 1, '0);
        step(1, 0, 0, 0, 0, '0);
        for (int i = 1; i <= 4; i++) step(1, 1, 0, 0, 0, 64'(i));
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, '0);
        step(1, 0, 1, 0, 0, '0);
        step(1, 0, 0, 1, 0, '0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 64'(16'h100 + i));
        step(1, 1, 0, 0, 0, 64'hDEAD);
        step(1, 1, 1, 0, 0, 64'hBEEF);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0, '0);
        step(1, 0, 0, 1, 0, '0);
        for (int i = 0; i < 12; i++) step(1, 1, (i % 2) == 1, 0, 0, 64'(i));
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, {$urandom, $urandom});
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 1, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, {$urandom, $urandom});
        step(1, 1, 1, 0, 1, {$urandom, $urandom});
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) > 3, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 199) == 0, {$urandom, $urandom});
        end
        step(1, 0, 0, 0, 0, '0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("a.sb_drain", 64'(sb[0].size()), 64'd0);
        chk("b.sb_drain", 64'(sb[1].size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
